// File: rtl/if_id_queue.sv
// IF/ID instruction queue: buffers {instruction, next-PC} pairs between fetch and decode, with branch flush.
// Latency: one cycle push-to-head; zero with IFQ_BYPASS_EN when empty and decode is ready.
// Backpressure: in_ready drops when full, and a same-cycle pop does not free the slot; flush overrides push and pop.
module if_id_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              in_instruction,
    input  logic [31:0]              in_npc,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [31:0]              out_instruction,
    output logic [31:0]              out_npc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [7:0]               flush_count
);

    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] npc;
    } ifq_entry_t;

    ifq_entry_t          mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                bypass;
    logic                push;
    logic                pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;

`ifdef IFQ_BYPASS_EN
    // An empty queue with decode ready hands the fetch word straight through.
    assign bypass = empty && in_valid && out_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign push = in_valid && in_ready && !flush && !bypass;
    assign pop  = !empty && out_ready && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            flush_count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            if (!empty && flush_count != 8'hFF)
                flush_count <= flush_count + 8'd1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; validity is carried entirely by count.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= '{instruction: in_instruction, npc: in_npc};
    end

    always_comb begin
        out_valid       = 1'b0;
        out_instruction = NOP;
        out_npc         = '0;
        if (!empty) begin
            out_valid       = 1'b1;
            out_instruction = mem[rd_ptr].instruction;
            out_npc         = mem[rd_ptr].npc;
        end
`ifdef IFQ_BYPASS_EN
        else if (bypass) begin
            out_valid       = 1'b1;
            out_instruction = in_instruction;
            out_npc         = in_npc;
        end
`endif
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: scoreboard of pushed entries compared against the head on every pop.
// Follows IFQ_BYPASS_EN so the same bench covers both builds.
module tb_if_id_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] n;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instruction = '0;
    logic [31:0] in_npc = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_npc;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic [7:0]  flush_count;

    int   checks = 0;
    int   passed = 0;
    ent_t sb[$];
    ent_t e;
    int   pre;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_instruction(in_instruction), .in_npc(in_npc), .in_ready(in_ready),
        .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .out_instruction(out_instruction), .out_npc(out_npc),
        .count(count), .full(full), .empty(empty), .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] npc,
                         input logic ordy, input logic fl);
        in_valid       = iv;
        in_instruction = ins;
        in_npc         = npc;
        out_ready      = ordy;
        flush          = fl;
    endtask

    // Model of acceptance: room is judged on occupancy before this cycle's pop.
    task automatic book(input int pre_size);
        logic byp;
        byp = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp = (pre_size == 0) && out_ready;
`endif
        if (in_valid && !flush && pre_size < DEPTH && !byp)
            sb.push_back('{i: in_instruction, n: in_npc});
    endtask

    task automatic test_reset;
        #2;
        checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
        checks++; if (empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_flags got empty=%b full=%b in_ready=%b want 1 0 1", empty, full, in_ready); else passed++;
        checks++; if (out_valid !== 1'b0 || out_instruction !== 32'h13 || out_npc !== 32'h0)
            $display("FAIL reset_out got v=%b i=%h n=%h want 0 00000013 0", out_valid, out_instruction, out_npc); else passed++;
        checks++; if (flush_count !== 8'd0) $display("FAIL reset_fc got %0d want 0", flush_count); else passed++;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_order;
        drive(1'b1, 32'hA0, 32'd4, 1'b0, 1'b0);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL order_no_comb got %b want 0", out_valid); else passed++;
        book(sb.size());
        tick;
        checks++; if (out_valid !== 1'b1 || out_instruction !== 32'hA0)
            $display("FAIL order_latency got v=%b i=%h want 1 000000a0", out_valid, out_instruction); else passed++;
        for (int k = 1; k < 3; k++) begin
            drive(1'b1, 32'hA0 + k, 32'd4 * (k + 1), 1'b0, 1'b0);
            #1; book(sb.size()); tick;
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if (count !== 3'd3) $display("FAIL order_count got %0d want 3", count); else passed++;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            #1;
            pre = sb.size();
            checks++; if (out_valid !== (pre != 0)) $display("FAIL order_valid got %b want %b", out_valid, pre != 0); else passed++;
            if (pre != 0) begin
                e = sb.pop_front();
                checks++; if (out_instruction !== e.i || out_npc !== e.n)
                    $display("FAIL order_data got %h/%h want %h/%h", out_instruction, out_npc, e.i, e.n); else passed++;
            end
            tick;
        end
        checks++; if (empty !== 1'b1 || count !== 3'd0) $display("FAIL order_empty got empty=%b count=%0d want 1 0", empty, count); else passed++;
    endtask

    task automatic test_full;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'hB0 + k, 32'h100 + 4 * k, 1'b0, 1'b0);
            #1; book(sb.size()); tick;
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hDEAD, 32'hDEAD, 1'b0, 1'b0);
            #1; book(sb.size());
            checks++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4)
                $display("FAIL full_flags got full=%b in_ready=%b count=%0d want 1 0 4", full, in_ready, count); else passed++;
            tick;
        end
        // Pop while full: the slot freed this cycle must not admit the waiting word.
        for (int k = 0; k < 8; k++) begin
            drive(k == 0, 32'hDEAD, 32'hDEAD, 1'b1, 1'b0);
            #1;
            pre = sb.size();
            checks++; if (out_valid !== (pre != 0)) $display("FAIL full_valid got %b want %b", out_valid, pre != 0); else passed++;
            if (pre != 0) begin
                e = sb.pop_front();
                checks++; if (out_instruction !== e.i || out_npc !== e.n)
                    $display("FAIL full_data got %h/%h want %h/%h", out_instruction, out_npc, e.i, e.n); else passed++;
            end
            book(pre);
            tick;
            if (k == 0) begin
                checks++; if (count !== 3'd3) $display("FAIL full_pop_count got %0d want 3", count); else passed++;
            end
        end
        checks++; if (empty !== 1'b1) $display("FAIL full_drained got empty=%b want 1", empty); else passed++;
    endtask

    task automatic test_flush;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'hC0 + k, 32'h200 + k, 1'b0, 1'b0);
            #1; book(sb.size()); tick;
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if (count !== 3'd2) $display("FAIL flush_pre_count got %0d want 2", count); else passed++;
        drive(1'b1, 32'hC9, 32'hC9, 1'b1, 1'b1);
        tick;
        sb.delete();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_instruction !== 32'h13)
            $display("FAIL flush_clear got count=%0d v=%b i=%h want 0 0 00000013", count, out_valid, out_instruction); else passed++;
        checks++; if (flush_count !== 8'd1) $display("FAIL flush_count1 got %0d want 1", flush_count); else passed++;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if (flush_count !== 8'd1) $display("FAIL flush_empty_fc got %0d want 1", flush_count); else passed++;
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'hD0 + k, 32'h300 + k, 1'b0, 1'b0);
            #1; book(sb.size()); tick;
        end
        for (int k = 0; k < 22; k++) begin
            drive(k < 20, 32'h1000 + k, 32'h4 * k, 1'b1, 1'b0);
            #1;
            pre = sb.size();
            checks++; if (out_valid !== (pre != 0)) $display("FAIL b2b_valid got %b want %b", out_valid, pre != 0); else passed++;
            if (pre != 0) begin
                e = sb.pop_front();
                checks++; if (out_instruction !== e.i || out_npc !== e.n)
                    $display("FAIL b2b_data got %h/%h want %h/%h", out_instruction, out_npc, e.i, e.n); else passed++;
            end
            book(pre);
            tick;
            if (k < 20) begin
                checks++; if (count !== 3'd2) $display("FAIL b2b_count got %0d want 2", count); else passed++;
            end
        end
        checks++; if (empty !== 1'b1) $display("FAIL b2b_empty got %b want 1", empty); else passed++;
    endtask

    task automatic test_bypass;
        drive(1'b1, 32'h0050_0093, 32'h40, 1'b1, 1'b0);
        #1;
`ifdef IFQ_BYPASS_EN
        checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0050_0093 || out_npc !== 32'h40)
            $display("FAIL bypass_same got v=%b i=%h n=%h want 1 00500093 40", out_valid, out_instruction, out_npc); else passed++;
        tick;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL bypass_count got count=%0d v=%b want 0 0", count, out_valid); else passed++;
`else
        checks++; if (out_valid !== 1'b0) $display("FAIL bypass_none got %b want 0", out_valid); else passed++;
        book(sb.size());
        tick;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if (out_valid !== 1'b1 || out_instruction !== 32'h0050_0093 || count !== 3'd1)
            $display("FAIL bypass_late got v=%b i=%h count=%0d want 1 00500093 1", out_valid, out_instruction, count); else passed++;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        e = sb.pop_front();
        checks++; if (out_instruction !== e.i || out_npc !== e.n)
            $display("FAIL bypass_pop got %h/%h want %h/%h", out_instruction, out_npc, e.i, e.n); else passed++;
        tick;
        checks++; if (empty !== 1'b1) $display("FAIL bypass_empty got %b want 1", empty); else passed++;
`endif
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'hE0 + k, 32'h0, 1'b0, 1'b0); tick;
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);      tick;
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hF0 + k, 32'h500 + k, 1'b0, 1'b0); tick;
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if (count !== 3'd3 || flush_count !== 8'd5)
            $display("FAIL rst_mid_pre got count=%0d fc=%0d want 3 5", count, flush_count); else passed++;
        #2 reset = 1'b1;
        #1;
        checks++; if (count !== 3'd0 || flush_count !== 8'd0)
            $display("FAIL rst_mid_clear got count=%0d fc=%0d want 0 0", count, flush_count); else passed++;
        checks++; if (out_valid !== 1'b0 || out_instruction !== 32'h13 || out_npc !== 32'h0 || empty !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL rst_mid_out got v=%b i=%h n=%h e=%b r=%b want 0 00000013 0 1 1",
                     out_valid, out_instruction, out_npc, empty, in_ready); else passed++;
        sb.delete();
        tick;
        reset = 1'b0;
        drive(1'b1, 32'h77, 32'h88, 1'b0, 1'b0);
        tick;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if (count !== 3'd1 || out_instruction !== 32'h77 || out_npc !== 32'h88)
            $display("FAIL rst_first_push got count=%0d i=%h n=%h want 1 00000077 88", count, out_instruction, out_npc); else passed++;
        checks++; if (flush_count !== 8'd0) $display("FAIL rst_no_fc got %0d want 0", flush_count); else passed++;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick;
    endtask

    task automatic test_flush_saturate;
        // One flush of a non-empty queue is already on record from the previous scenario.
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, k, k, 1'b0, 1'b0);  tick;
            drive(1'b0, 0, 0, 1'b0, 1'b1);  tick;
            if (k == 99) begin
                checks++; if (flush_count !== 8'd101) $display("FAIL fc_mid got %0d want 101", flush_count); else passed++;
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if (flush_count !== 8'hFF) $display("FAIL fc_sat got %0d want 255", flush_count); else passed++;
    endtask

    initial begin
        test_reset;
        test_order;
        test_full;
        test_flush;
        test_back_to_back;
        test_bypass;
        test_reset_mid;
        test_flush_saturate;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
